// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the transmitter, the receiver and the frame
// control state machine.
//   tx_state_t    : transmitter state (IDLE, XMIT)
//   FRAME_BITS    : bits per 8N1 frame (start + 8 data + stop)
//   DEF_BAUD_DIV  : clocks per bit for 50 MHz / 19200 baud
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      XMIT = 1'b1
   } tx_state_t;

   localparam int FRAME_BITS   = 10;
   localparam int DEF_BAUD_DIV = 2604;

   // Index of the stop bit within a frame; the frame ends when its period ends.
   localparam logic [3:0] LAST_BIT_IDX = 4'(FRAME_BITS - 1);

endpackage : uart_pkg

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Baud-rate divider. Counts clocks while enabled and pulses tick on the last
// clock of every BAUD_DIV-clock bit period, then restarts from zero.
// Ports:
//   clk    in  system clock, all logic on posedge
//   rst_n  in  synchronous active-low reset
//   en     in  count enable (bit period in progress)
//   clr    in  restart the bit period from zero (takes priority over en)
//   tick   out one-clock pulse when the counter holds BAUD_DIV-1 and en is set
// -----------------------------------------------------------------------------
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int BAUD_DIV = DEF_BAUD_DIV
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int              CNT_W    = $clog2(BAUD_DIV);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BAUD_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // The counter is sized to reach exactly BAUD_DIV-1 and is cleared on the
   // tick, so it never wraps.
   assign tick = en && (cnt_q == LAST_CNT);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : uart_baud_tick

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// 8N1 serial transmitter. One byte is accepted per trmt pulse while idle and
// shifted out LSB first between a low start bit and a high stop bit, each bit
// held BAUD_DIV clocks. tx_done is a level that rises at the end of the stop
// bit and stays high until the next byte is accepted.
// Ports:
//   clk      in  system clock, all logic on posedge
//   rst_n    in  synchronous active-low reset
//   trmt     in  start request, only honoured while idle
//   tx_data  in  byte to send, captured in the cycle trmt is accepted
//   TX       out serial line, registered, idles high
//   tx_done  out frame complete level
// -----------------------------------------------------------------------------
module uart_tx
   import uart_pkg::*;
#(
   parameter int BAUD_DIV = DEF_BAUD_DIV
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       trmt,
   input  logic [7:0] tx_data,
   output logic       TX,
   output logic       tx_done
);

   tx_state_t  state_q;
   logic [3:0] bit_cnt_q;
   logic [8:0] shift_q;
   logic       tx_done_q;

   logic accept;
   logic baud_en;
   logic shift_tick;

   assign accept  = (state_q == IDLE) && trmt;
   assign baud_en = (state_q == XMIT);

   uart_baud_tick #(
      .BAUD_DIV (BAUD_DIV)
   ) u_baud (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (baud_en),
      .clr   (accept),
      .tick  (shift_tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         shift_q   <= '1;
         bit_cnt_q <= '0;
         tx_done_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (trmt) begin
                  // Bit 0 is the start bit, so the line drops on the next edge.
                  shift_q   <= {tx_data, 1'b0};
                  bit_cnt_q <= '0;
                  tx_done_q <= 1'b0;
                  state_q   <= XMIT;
               end
            end
            XMIT: begin
               if (shift_tick) begin
                  // Ones shifted in at the top form the stop bit and leave the
                  // register all ones, which is the idle line level.
                  shift_q <= {1'b1, shift_q[8:1]};
                  if (bit_cnt_q == LAST_BIT_IDX) begin
                     bit_cnt_q <= '0;
                     tx_done_q <= 1'b1;
                     state_q   <= IDLE;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end
               end
            end
         endcase
      end
   end

   assign TX      = shift_q[0];
   assign tx_done = tx_done_q;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

   localparam int BD = 16;
   localparam int FB = 10;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       trmt    = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       TX;
   logic       tx_done;

   uart_tx #(.BAUD_DIV(BD)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .trmt    (trmt),
      .tx_data (tx_data),
      .TX      (TX),
      .tx_done (tx_done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model (frame timeline) ----------------
   int         cyc       = 0;
   bit         m_busy    = 1'b0;
   bit         m_done    = 1'b0;
   int         m_start   = 0;
   logic [7:0] m_byte    = 8'h00;
   int         rst_epoch = 0;
   logic [7:0] sent [0:1023];
   int         n_sent    = 0;

   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         m_busy = 1'b0;
         m_done = 1'b0;
         rst_epoch++;
      end else if (m_busy) begin
         if (cyc - m_start == FB * BD) begin
            m_busy = 1'b0;
            m_done = 1'b1;
         end
      end else if (trmt) begin
         m_busy  = 1'b1;
         m_done  = 1'b0;
         m_start = cyc;
         m_byte  = tx_data;
         if (n_sent < 1024) sent[n_sent] = tx_data;
         n_sent++;
      end
   end

   // ---------------- per-cycle compare + bench UART receiver ----------------
   logic [9:0] fr;
   logic       exp_tx;
   int         k;
   int         dec_epoch  = 0;
   bit         dec_on     = 1'b0;
   int         dec_n      = 0;
   int         dec_idx    = 0;
   int         n_decoded  = 0;
   logic [9:0] dec_bits   = '0;
   logic       prev_tx    = 1'b1;

   always @(negedge clk) begin
      if (rst_epoch > 0) begin
         if (m_busy) begin
            k      = cyc - m_start;
            fr     = {1'b1, m_byte, 1'b0};
            exp_tx = fr[k / BD];
         end else begin
            exp_tx = 1'b1;
         end
         check("tx_line", 32'(TX), 32'(exp_tx));
         check("tx_done", 32'(tx_done), 32'(m_done));

         if (dec_epoch != rst_epoch) begin
            dec_epoch = rst_epoch;
            dec_on    = 1'b0;
            dec_idx   = n_sent;
         end else if (!dec_on) begin
            if (prev_tx === 1'b1 && TX === 1'b0) begin
               dec_on = 1'b1;
               dec_n  = 0;
            end
         end else begin
            dec_n++;
            if (dec_n % BD == BD / 2) begin
               dec_bits[dec_n / BD] = TX;
               if (dec_n / BD == FB - 1) begin
                  dec_on = 1'b0;
                  n_decoded++;
                  check("dec_start", 32'(dec_bits[0]), 32'(0));
                  check("dec_stop", 32'(dec_bits[9]), 32'(1));
                  if (dec_idx < n_sent && dec_idx < 1024) begin
                     check("dec_byte", 32'(dec_bits[8:1]), 32'(sent[dec_idx]));
                  end else begin
                     check("dec_unexpected_frame", 32'(dec_idx), 32'(n_sent - 1));
                  end
                  dec_idx++;
               end
            end
         end
         prev_tx = TX;
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      tx_data = b;
      trmt    = 1'b1;
      tick(1);
      trmt    = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (tx_done !== 1'b1 && n < 400) begin
         tick(1);
         n++;
      end
      check(name, 32'(tx_done), 32'(1));
   endtask

   logic [0:9] a5_bits;
   int         first_done;
   int         gap;
   logic [7:0] rb;

   initial begin
      a5_bits = 10'b0101001011;

      // reset state
      rst_n = 1'b0;
      tick(3);
      check("reset_tx", 32'(TX), 32'(1));
      check("reset_done", 32'(tx_done), 32'(0));
      rst_n = 1'b1;
      tick(2);

      // 1: single frame A5, literal bit values and latency
      send(8'hA5);
      first_done = -1;
      for (int n = 0; n < 200; n++) begin
         if (n < FB * BD && n % BD == BD / 2) check("a5_bit", 32'(TX), 32'(a5_bits[n / BD]));
         if (n > 0 && n % BD == 0 && n < FB * BD) check("a5_no_done_midframe", 32'(tx_done), 32'(0));
         if (tx_done === 1'b1 && first_done < 0) first_done = n;
         tick(1);
      end
      check("a5_done_clk", 32'(first_done + 1), 32'(161));
      check("a5_done_hold", 32'(tx_done), 32'(1));

      // 2: trmt during a frame is ignored
      tick(3);
      send(8'hA5);
      tick(40);
      tx_data = 8'h00;
      trmt    = 1'b1;
      tick(5);
      check("busy_done_low", 32'(tx_done), 32'(0));
      trmt = 1'b0;
      wait_done("t2_done");
      tick(20);
      check("t2_done_hold", 32'(tx_done), 32'(1));

      // 3: back-to-back as the control SM drives it
      send(8'h3C);
      wait_done("t3_done1");
      check("t3_idle_tx", 32'(TX), 32'(1));
      tx_data = 8'hC3;
      trmt    = 1'b1;
      tick(1);
      trmt    = 1'b0;
      check("t3_b2b_done_clr", 32'(tx_done), 32'(0));
      check("t3_b2b_start", 32'(TX), 32'(0));
      wait_done("t3_done2");

      // 4: reset during bit 4, then a clean frame
      tick(2);
      send(8'h55);
      tick(BD * 4 + 3);
      rst_n = 1'b0;
      tick(1);
      check("t4_rst_tx", 32'(TX), 32'(1));
      check("t4_rst_done", 32'(tx_done), 32'(0));
      rst_n = 1'b1;
      tick(3);
      check("t4_idle_tx", 32'(TX), 32'(1));
      send(8'h81);
      wait_done("t4_done");

      // 5: all-ones and all-zeros data
      tick(1);
      send(8'hFF);
      wait_done("t5_done_ff");
      tick(1);
      send(8'h00);
      wait_done("t5_done_00");

      // 6: random bytes with random idle gaps (including back-to-back)
      for (int i = 0; i < 200; i++) begin
         rb  = 8'($urandom_range(0, 255));
         gap = $urandom_range(0, 3);
         if (gap > 0) tick(gap);
         send(rb);
         wait_done("t6_done");
      end

      tick(5);
      check("frames_decoded", 32'(n_decoded), 32'(207));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule : tb_uart_tx
